// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Input front end for the minesweeper VGA top. Each raw push button is
//   synchronised, debounced and (optionally) auto-repeated by its own small
//   FSM, producing a one-cycle press pulse and a debounced level.
//
// Ports
//   clk        in   1          pixel clock (shared with VGA top)
//   rst_n      in   1          asynchronous, active-low reset
//   ena        in   1          block enable; freezes FSMs/counters when low
//   btn_in     in   N_BUTTONS  raw asynchronous button levels, 1 = pressed
//   btn_pulse  out  N_BUTTONS  one-cycle pulse per accepted press or repeat
//   btn_level  out  N_BUTTONS  debounced button level, 1 = pressed
//
// Bit order of the button vectors: 0..4 = left, right, up, down, press.
// CNT_W must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) - 1.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int                   N_BUTTONS       = 5,
    parameter int                   DEBOUNCE_CYCLES = 250000,
    parameter int                   REPEAT_DELAY    = 12500000,
    parameter int                   REPEAT_PERIOD   = 3125000,
    parameter logic [N_BUTTONS-1:0] REPEAT_MASK     = 5'b01111,
    parameter int                   CNT_W           = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [N_BUTTONS-1:0] btn_in,
    output logic [N_BUTTONS-1:0] btn_pulse,
    output logic [N_BUTTONS-1:0] btn_level
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_HELD,
        S_RPT,
        S_REL
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // Stage p0/p1: two-flop synchroniser, deliberately independent of ena so
    // the FSMs see a settled level the moment the block is re-enabled.
    logic [N_BUTTONS-1:0] sync_p0;
    logic [N_BUTTONS-1:0] sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: per-button debounce / auto-repeat FSM with registered outputs.
    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             pulse_p2;
        logic             level_p2;
        logic             pulse_nxt;
        logic             level_nxt;

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt + CNT_ONE;
            pulse_nxt = 1'b0;
            level_nxt = level_p2;
            case (state)
                S_IDLE: begin
                    cnt_nxt = '0;
                    if (sync_p1[i]) state_nxt = S_ARM;
                end
                S_ARM: begin
                    if (!sync_p1[i]) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_nxt = S_HELD;
                        cnt_nxt   = '0;
                        pulse_nxt = 1'b1;
                        level_nxt = 1'b1;
                    end
                end
                S_HELD: begin
                    if (!sync_p1[i]) begin
                        state_nxt = S_REL;
                        cnt_nxt   = '0;
                    end else if (cnt == DLY_LAST) begin
                        if (REPEAT_MASK[i]) begin
                            state_nxt = S_RPT;
                            cnt_nxt   = '0;
                            pulse_nxt = 1'b1;
                        end else begin
                            // Non-repeating button: park the counter so it
                            // never wraps back into a false repeat.
                            cnt_nxt = cnt;
                        end
                    end
                end
                S_RPT: begin
                    if (!sync_p1[i]) begin
                        state_nxt = S_REL;
                        cnt_nxt   = '0;
                    end else if (cnt == PER_LAST) begin
                        cnt_nxt   = '0;
                        pulse_nxt = 1'b1;
                    end
                end
                S_REL: begin
                    // A return to 1 during release is treated as bounce: back
                    // to HELD with the repeat delay restarted, no new pulse.
                    if (sync_p1[i]) begin
                        state_nxt = S_HELD;
                        cnt_nxt   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                        level_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= S_IDLE;
                cnt      <= '0;
                pulse_p2 <= 1'b0;
                level_p2 <= 1'b0;
            end else if (ena) begin
                state    <= state_nxt;
                cnt      <= cnt_nxt;
                pulse_p2 <= pulse_nxt;
                level_p2 <= level_nxt;
            end else begin
                pulse_p2 <= 1'b0;
            end
        end

        assign btn_pulse[i] = pulse_p2;
        assign btn_level[i] = level_p2;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Table-driven bench for button_conditioner with short timing parameters
//   (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3). Each test fills a
//   table of edge ranges with the inputs to drive and the outputs expected
//   after each edge; expectations go through a scoreboard queue and are
//   compared one time unit after the edge. Reset and mid-cycle checks are
//   hand-written around the tables.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_button_conditioner;

    localparam int NB = 5;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena   = 1'b1;
    logic [NB-1:0] btn_in = '0;
    logic [NB-1:0] btn_pulse;
    logic [NB-1:0] btn_level;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BUTTONS      (NB),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (3),
        .REPEAT_MASK    (5'b01111),
        .CNT_W          (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .btn_in   (btn_in),
        .btn_pulse(btn_pulse),
        .btn_level(btn_level)
    );

    typedef struct {
        int            e_first;
        int            e_last;
        logic          ena;
        logic [NB-1:0] btn;
        logic [NB-1:0] pulse;
        logic [NB-1:0] level;
    } vec_t;

    typedef struct {
        int            edge_no;
        logic [NB-1:0] pulse;
        logic [NB-1:0] level;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(int e_first, int e_last, logic en,
                                logic [NB-1:0] b, logic [NB-1:0] p,
                                logic [NB-1:0] l);
        vec_t v;
        v.e_first = e_first;
        v.e_last  = e_last;
        v.ena     = en;
        v.btn     = b;
        v.pulse   = p;
        v.level   = l;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int edge_no, logic [NB-1:0] act,
                         logic [NB-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %b, expected %b", name, edge_no, act, exp);
        end
    endtask

    // Starts and ends on a falling edge; edge 0 is the next rising edge.
    task automatic run_vectors(string tname);
        foreach (vecs[r]) begin
            for (int e = vecs[r].e_first; e <= vecs[r].e_last; e++) begin
                exp_t x;
                x.edge_no = e;
                x.pulse   = vecs[r].pulse;
                x.level   = vecs[r].level;
                ena    = vecs[r].ena;
                btn_in = vecs[r].btn;
                sb.push_back(x);
                @(posedge clk);
                #1;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s scoreboard empty at edge %0d", tname, e);
                end else begin
                    x = sb.pop_front();
                    check({tname, "_pulse"}, x.edge_no, btn_pulse, x.pulse);
                    check({tname, "_level"}, x.edge_no, btn_level, x.level);
                end
                @(negedge clk);
            end
        end
        vecs.delete();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n  = 1'b0;
        btn_in = '0;
        ena    = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: asynchronous reset while all buttons are held.
        reset_dut();
        add(0, 5, 1'b1, 5'h1F, 5'h00, 5'h00);
        add(6, 6, 1'b1, 5'h1F, 5'h1F, 5'h1F);
        run_vectors("t1_pre");
        check("t1_pulse_before_rst", 6, btn_pulse, 5'h1F);
        rst_n = 1'b0;
        #1;
        check("t1_rst_async_pulse", 6, btn_pulse, 5'h00);
        check("t1_rst_async_level", 6, btn_level, 5'h00);
        @(posedge clk);
        #1;
        check("t1_rst_held_pulse", 7, btn_pulse, 5'h00);
        check("t1_rst_held_level", 7, btn_level, 5'h00);
        @(negedge clk);
        rst_n = 1'b1;
        add(0, 5, 1'b1, 5'h1F, 5'h00, 5'h00);
        add(6, 6, 1'b1, 5'h1F, 5'h1F, 5'h1F);
        add(7, 9, 1'b1, 5'h1F, 5'h00, 5'h1F);
        run_vectors("t1_post");

        // Test 2: clean press on bit 0 with auto-repeat.
        reset_dut();
        add(0,  5,  1'b1, 5'h01, 5'h00, 5'h00);
        add(6,  6,  1'b1, 5'h01, 5'h01, 5'h01);
        add(7,  13, 1'b1, 5'h01, 5'h00, 5'h01);
        add(14, 14, 1'b1, 5'h01, 5'h01, 5'h01);
        add(15, 16, 1'b1, 5'h01, 5'h00, 5'h01);
        add(17, 17, 1'b1, 5'h01, 5'h01, 5'h01);
        add(18, 19, 1'b1, 5'h01, 5'h00, 5'h01);
        add(20, 20, 1'b1, 5'h01, 5'h01, 5'h01);
        add(21, 21, 1'b1, 5'h01, 5'h00, 5'h01);
        run_vectors("t2");

        // Test 3: press bounce on bit 1, never stable long enough.
        reset_dut();
        add(0, 2,  1'b1, 5'h02, 5'h00, 5'h00);
        add(3, 3,  1'b1, 5'h00, 5'h00, 5'h00);
        add(4, 6,  1'b1, 5'h02, 5'h00, 5'h00);
        add(7, 15, 1'b1, 5'h00, 5'h00, 5'h00);
        run_vectors("t3");

        // Test 4: bit 4 (no repeat) held 40 cycles, then released.
        reset_dut();
        add(0,  5,  1'b1, 5'h10, 5'h00, 5'h00);
        add(6,  6,  1'b1, 5'h10, 5'h10, 5'h10);
        add(7,  39, 1'b1, 5'h10, 5'h00, 5'h10);
        add(40, 45, 1'b1, 5'h00, 5'h00, 5'h10);
        add(46, 49, 1'b1, 5'h00, 5'h00, 5'h00);
        run_vectors("t4");

        // Test 5: release bounce on bit 2, button comes back and stays held.
        reset_dut();
        add(0,  5,  1'b1, 5'h04, 5'h00, 5'h00);
        add(6,  6,  1'b1, 5'h04, 5'h04, 5'h04);
        add(7,  9,  1'b1, 5'h04, 5'h00, 5'h04);
        add(10, 12, 1'b1, 5'h00, 5'h00, 5'h04);
        add(13, 22, 1'b1, 5'h04, 5'h00, 5'h04);
        add(23, 23, 1'b1, 5'h04, 5'h04, 5'h04);
        add(24, 25, 1'b1, 5'h04, 5'h00, 5'h04);
        add(26, 26, 1'b1, 5'h04, 5'h04, 5'h04);
        add(27, 28, 1'b1, 5'h04, 5'h00, 5'h04);
        add(29, 29, 1'b1, 5'h04, 5'h04, 5'h04);
        add(30, 30, 1'b1, 5'h04, 5'h00, 5'h04);
        run_vectors("t5");

        // Test 6: bits 0 and 3 together, ena low for 10 cycles during ARM.
        reset_dut();
        add(0,  3,  1'b1, 5'h09, 5'h00, 5'h00);
        add(4,  13, 1'b0, 5'h09, 5'h00, 5'h00);
        add(14, 15, 1'b1, 5'h09, 5'h00, 5'h00);
        add(16, 16, 1'b1, 5'h09, 5'h09, 5'h09);
        add(17, 18, 1'b1, 5'h09, 5'h00, 5'h09);
        run_vectors("t6");

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
